// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial ALU sequencer: ctrl bit positions,
// nibble width, FSM state encoding and the standard op codes.
package alu_pkg;

  // ctrl = {ex, nx, ey, ny, f, no}
  localparam int unsigned CTRL_EX = 5;
  localparam int unsigned CTRL_NX = 4;
  localparam int unsigned CTRL_EY = 3;
  localparam int unsigned CTRL_NY = 2;
  localparam int unsigned CTRL_F  = 1;
  localparam int unsigned CTRL_NO = 0;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [5:0] OP_ADD  = 6'b101010;
  localparam logic [5:0] OP_AND  = 6'b101000;
  localparam logic [5:0] OP_SUB  = 6'b111011;  // x - y
  localparam logic [5:0] OP_ZERO = 6'b000000;
  localparam logic [5:0] OP_ONES = 6'b010100;

endpackage

// File: rtl/alu_nibble_seq.sv
// Nibble-serial initiator for a shared 4-bit ALU slice. Computes a WIDTH-bit
// result LSB nibble first, rippling carry through an internal register.
// Optional feature macro: ALU_CARRY_IN_EN adds a cin port that seeds the
// carry register on an accepted start (multi-word add).
module alu_nibble_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctrl,
`ifdef ALU_CARRY_IN_EN
  input  logic             cin,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero,
  output logic             neg,
  output logic [3:0]       slice_x,
  output logic [3:0]       slice_y,
  output logic [5:0]       slice_c,
  output logic             slice_cin,
  input  logic [3:0]       slice_out,
  input  logic             slice_cout
);

  localparam int unsigned NIB   = WIDTH / NIBBLE_W;
  localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   x_l, y_l;
  logic [5:0]         ctrl_l;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W+1:0]   bit_base;
  logic               carry_q;
  logic               carry_init;
  logic [WIDTH-1:0]   res_final;

`ifdef ALU_CARRY_IN_EN
  assign carry_init = cin;
`else
  assign carry_init = 1'b0;
`endif

  assign bit_base = {idx, 2'b00};

  // Result as it will look after the current RUN edge; flags on the last
  // step are derived from this so they match the completed result.
  always_comb begin
    res_final = result;
    res_final[bit_base +: NIBBLE_W] = slice_out;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic, handshake outputs and slice drive
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    slice_x   = '0;
    slice_y   = '0;
    slice_cin = 1'b0;
    slice_c   = ctrl_l;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy      = 1'b1;
        slice_x   = x_l[bit_base +: NIBBLE_W];
        slice_y   = y_l[bit_base +: NIBBLE_W];
        slice_cin = carry_q;
        if (idx == LAST_IDX) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, nibble accumulation and final flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_l       <= '0;
      y_l       <= '0;
      ctrl_l    <= '0;
      idx       <= '0;
      carry_q   <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x_l     <= x;
            y_l     <= y;
            ctrl_l  <= ctrl;
            idx     <= '0;
            carry_q <= carry_init;
          end
        end
        RUN: begin
          result[bit_base +: NIBBLE_W] <= slice_out;
          carry_q <= slice_cout;
          idx     <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            carry_out <= slice_cout;
            zero      <= (res_final == '0);
            neg       <= res_final[WIDTH-1];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Self-checking bench for alu_nibble_seq (WIDTH=16) with a behavioural 4-bit
// ALU slice on the slice_* ports. Expected values come from a full-width
// reference model pushed to a scoreboard when each operation is started.
module tb_alu_nibble_seq;
  import alu_pkg::*;

  localparam int unsigned W = 16;
`ifdef ALU_CARRY_IN_EN
  localparam bit CIN_EN = 1'b1;
`else
  localparam bit CIN_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] x_i, y_i;
  logic [5:0]   ctrl_i;
  logic         cin_i;
  logic         busy, done;
  logic [W-1:0] result;
  logic         carry_out, zero, neg;
  logic [3:0]   slice_x, slice_y, slice_out;
  logic [5:0]   slice_c;
  logic         slice_cin, slice_cout;

  typedef struct {
    logic [W-1:0] res;
    logic         cy;
    logic         z;
    logic         n;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  alu_nibble_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .x          (x_i),
    .y          (y_i),
    .ctrl       (ctrl_i),
`ifdef ALU_CARRY_IN_EN
    .cin        (cin_i),
`endif
    .busy       (busy),
    .done       (done),
    .result     (result),
    .carry_out  (carry_out),
    .zero       (zero),
    .neg        (neg),
    .slice_x    (slice_x),
    .slice_y    (slice_y),
    .slice_c    (slice_c),
    .slice_cin  (slice_cin),
    .slice_out  (slice_out),
    .slice_cout (slice_cout)
  );

  // Behavioural 4-bit ALU slice; carry out is 0 in AND mode
  logic [3:0] sxa, syb, ss;
  logic [4:0] ssum;
  always_comb begin
    sxa = slice_c[CTRL_EX] ? slice_x : 4'h0;
    if (slice_c[CTRL_NX]) sxa = ~sxa;
    syb = slice_c[CTRL_EY] ? slice_y : 4'h0;
    if (slice_c[CTRL_NY]) syb = ~syb;
    if (slice_c[CTRL_F]) ssum = {1'b0, sxa} + {1'b0, syb} + {4'b0, slice_cin};
    else                 ssum = {1'b0, sxa & syb};
    ss = ssum[3:0];
    if (slice_c[CTRL_NO]) ss = ~ss;
    slice_out  = ss;
    slice_cout = ssum[4];
  end

  // Full-width reference; nibble ripple of the slice equals one wide operation
  function automatic exp_t model(input logic [5:0] c, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic ci);
    exp_t         e;
    logic [W-1:0] xa, yb, s;
    logic [W:0]   sum;
    xa = c[CTRL_EX] ? a : '0;
    if (c[CTRL_NX]) xa = ~xa;
    yb = c[CTRL_EY] ? b : '0;
    if (c[CTRL_NY]) yb = ~yb;
    if (c[CTRL_F]) sum = {1'b0, xa} + {1'b0, yb} + {{W{1'b0}}, ci};
    else           sum = {1'b0, xa & yb};
    s = sum[W-1:0];
    if (c[CTRL_NO]) s = ~s;
    e.res = s;
    e.cy  = c[CTRL_F] ? sum[W] : 1'b0;
    e.z   = (s == '0);
    e.n   = s[W-1];
    return e;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Start one operation, wait (bounded) for done and compare to the scoreboard.
  // poke=1 also pulses start with other operands during RUN and in the DONE cycle.
  task automatic run_op(input logic [5:0] c, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic ci, input bit poke);
    exp_t e;
    int   edges;
    bit   seen;
    @(negedge clk);
    ctrl_i = c; x_i = a; y_i = b; cin_i = ci; start = 1'b1;
    sb.push_back(model(c, a, b, ci & CIN_EN));
    edges = 0;
    seen  = 1'b0;
    repeat (20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      start = 1'b0;
      if (edges == 1) check_eq("busy_run", {31'b0, busy}, 32'd1);
      if (poke && edges == 2) begin
        start = 1'b1; x_i = 16'hAAAA; y_i = 16'h5555; ctrl_i = OP_AND;
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("done_seen", {31'b0, seen}, 32'd1);
    check_eq("latency", edges, 32'd5);
    check_eq("busy_done", {31'b0, busy}, 32'd1);
    if (sb.size() > 0) e = sb.pop_front();
    else e = '{res: '0, cy: 1'b0, z: 1'b0, n: 1'b0};
    check_eq("result", {16'b0, result}, {16'b0, e.res});
    check_eq("carry_out", {31'b0, carry_out}, {31'b0, e.cy});
    check_eq("zero", {31'b0, zero}, {31'b0, e.z});
    check_eq("neg", {31'b0, neg}, {31'b0, e.n});
    if (poke) begin
      start = 1'b1; x_i = 16'h1111; y_i = 16'h0F0F; ctrl_i = OP_ONES;
    end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check_eq("done_one_cycle", {31'b0, done}, 32'd0);
    check_eq("idle_after", {31'b0, busy}, 32'd0);
    check_eq("result_hold", {16'b0, result}, {16'b0, e.res});
  endtask

  initial begin
    int pulses;
    logic [5:0] ops [5];
    ops[0] = OP_ADD; ops[1] = OP_AND; ops[2] = OP_SUB; ops[3] = OP_ZERO; ops[4] = OP_ONES;

    rst_n = 1'b0; start = 1'b0; x_i = '0; y_i = '0; ctrl_i = '0; cin_i = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_done", {31'b0, done}, 32'd0);
    check_eq("rst_result", {16'b0, result}, 32'd0);
    check_eq("rst_flags", {29'b0, carry_out, zero, neg}, 32'd0);
    check_eq("rst_slice", {23'b0, slice_x, slice_y, slice_cin}, 32'd0);
    check_eq("rst_slice_c", {26'b0, slice_c}, 32'd0);
    rst_n = 1'b1;

    run_op(OP_ADD, 16'h00FF, 16'h0001, 1'b0, 1'b0);
    run_op(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    run_op(OP_SUB, 16'h1234, 16'h0235, 1'b0, 1'b0);
    run_op(OP_AND, 16'hF0F0, 16'h3C3C, 1'b0, 1'b0);
    run_op(OP_ONES, 16'h1234, 16'h5678, 1'b0, 1'b0);
    run_op(OP_ZERO, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    // start during RUN and DONE is ignored; the next start is accepted
    run_op(OP_ADD, 16'h1000, 16'h2345, 1'b0, 1'b1);
    run_op(OP_SUB, 16'h0001, 16'h0002, 1'b0, 1'b0);

    // Reset after the 2nd RUN edge aborts without a done pulse
    @(negedge clk);
    ctrl_i = OP_ADD; x_i = 16'h1111; y_i = 16'h2222; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("abort_busy", {31'b0, busy}, 32'd0);
    check_eq("abort_done", {31'b0, done}, 32'd0);
    check_eq("abort_result", {16'b0, result}, 32'd0);
    rst_n = 1'b1;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check_eq("abort_no_done", pulses, 32'd0);
    run_op(OP_ADD, 16'h0003, 16'h0004, 1'b0, 1'b0);

    // Carry-in seed: 0x0001 with the feature, 0x0000 without
    run_op(OP_ADD, 16'h0000, 16'h0000, 1'b1, 1'b0);
    run_op(OP_SUB, 16'h5000, 16'h1000, 1'b1, 1'b0);

    for (int i = 0; i < 6; i++) begin
      run_op(ops[$urandom_range(0, 4)], 16'($urandom), 16'($urandom),
             1'($urandom_range(0, 1)), 1'b0);
    end

    check_eq("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
